// File: rtl/port_bus_pkg.sv
// Shared constants and types for the memory-mapped port subsystem.
// Address map, status bit positions and decoder select codes.
package port_bus_pkg;

   localparam logic [15:0] CON_DATA = 16'hFF00;
   localparam logic [15:0] CON_STAT = 16'hFF01;
   localparam logic [15:0] TIMER    = 16'hFF02;
   localparam logic [15:0] SWITCH   = 16'hFF03;

   localparam int STAT_FULL  = 0;
   localparam int STAT_EMPTY = 1;
   localparam int STAT_BAD   = 2;
   localparam int STAT_OVF   = 3;
   localparam int STAT_CNT   = 4;

   typedef enum logic [2:0] {
      SEL_RAM,
      SEL_CDATA,
      SEL_CSTAT,
      SEL_TIMER,
      SEL_SWITCH,
      SEL_OTHER
   } sel_e;

endpackage

// File: rtl/port_fifo.sv
// Console TX FIFO: circular buffer with occupancy count.
// Head entry is presented combinationally; zero while empty.
module port_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  logic [WIDTH-1:0]               wdata,
   input  logic                           pop,
   output logic [WIDTH-1:0]               rdata,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == DEPTH[$clog2(DEPTH+1)-1:0]);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/port_bus.sv
// Port subsystem behind the cpu IN/OUT interface: data RAM,
// console TX FIFO, free-running timer and synchronised switches.
import port_bus_pkg::*;

module port_bus #(
   parameter int WORD_SIZE  = 16,
   parameter int RAM_DEPTH  = 256,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WORD_SIZE-1:0] portaddr,
   input  logic [WORD_SIZE-1:0] portval,
   input  logic                 portget,
   input  logic                 portset,
   output logic [WORD_SIZE-1:0] portout,
   input  logic [WORD_SIZE-1:0] switches,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready
);

   localparam int AW = $clog2(RAM_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   localparam logic [WORD_SIZE-1:0] A_CDATA  = WORD_SIZE'(CON_DATA);
   localparam logic [WORD_SIZE-1:0] A_CSTAT  = WORD_SIZE'(CON_STAT);
   localparam logic [WORD_SIZE-1:0] A_TIMER  = WORD_SIZE'(TIMER);
   localparam logic [WORD_SIZE-1:0] A_SWITCH = WORD_SIZE'(SWITCH);

   logic [WORD_SIZE-1:0] ram [RAM_DEPTH];
   logic [WORD_SIZE-1:0] timer;
   logic [WORD_SIZE-1:0] sync1;
   logic [WORD_SIZE-1:0] sync2;
   logic [WORD_SIZE-1:0] rd_val;
   logic [WORD_SIZE-1:0] stat;
   logic [AW-1:0]        ram_idx;
   logic [CW-1:0]        count;
   logic                 in_ram;
   logic                 bad_addr;
   logic                 overflow;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   sel_e                 sel;

   assign ram_idx = portaddr[AW-1:0];
   assign in_ram  = (portaddr >> AW) == '0;

   always_comb begin
      sel = SEL_OTHER;
      unique case (1'b1)
         in_ram:                 sel = SEL_RAM;
         (portaddr == A_CDATA):  sel = SEL_CDATA;
         (portaddr == A_CSTAT):  sel = SEL_CSTAT;
         (portaddr == A_TIMER):  sel = SEL_TIMER;
         (portaddr == A_SWITCH): sel = SEL_SWITCH;
         default:                sel = SEL_OTHER;
      endcase
   end

   assign pop      = tx_valid & tx_ready;
   assign push     = portset & (sel == SEL_CDATA);
   assign tx_valid = ~empty;

   port_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (portval[7:0]),
      .pop   (pop),
      .rdata (tx_data),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      stat                 = '0;
      stat[STAT_FULL]      = full;
      stat[STAT_EMPTY]     = empty;
      stat[STAT_BAD]       = bad_addr;
      stat[STAT_OVF]       = overflow;
      stat[STAT_CNT +: 4]  = 4'(count);
   end

   always_comb begin
      rd_val = '1;
      unique case (sel)
         SEL_RAM:    rd_val = ram[ram_idx];
         SEL_CDATA:  rd_val = '0;
         SEL_CSTAT:  rd_val = stat;
         SEL_TIMER:  rd_val = timer;
         SEL_SWITCH: rd_val = sync2;
         default:    rd_val = '1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (portset && sel == SEL_RAM) ram[ram_idx] <= portval;
   end

   // later assignments let a same-edge sticky set beat the read-clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         portout  <= '0;
         timer    <= '0;
         sync1    <= '0;
         sync2    <= '0;
         bad_addr <= 1'b0;
         overflow <= 1'b0;
      end else begin
         sync1 <= switches;
         sync2 <= sync1;
         if (portget) portout <= rd_val;
         if (portset && sel == SEL_TIMER) timer <= portval;
         else                             timer <= timer + 1'b1;
         if (portget && sel == SEL_CSTAT) begin
            bad_addr <= 1'b0;
            overflow <= 1'b0;
         end
         if ((portget || portset) && sel == SEL_OTHER) bad_addr <= 1'b1;
         if (push && full && !pop) overflow <= 1'b1;
      end
   end

endmodule
